// File: rtl/ysyx_23060184_csr_access_unit_pkg.sv
// Shared constants for the CSR access unit: CSR addresses, funct3 op codes,
// FSM state encoding and the ecall cause value.
package ysyx_23060184_csr_access_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_SYS = 3'b000;
  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int unsigned CAUSE_ECALL_M = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RET   = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  function automatic logic f3_is_zicsr(input logic [2:0] f3);
    return (f3 != F3_SYS) && (f3 != 3'b100);
  endfunction

endpackage

// File: rtl/ysyx_23060184_csr_access_unit_alu.sv
// New-value compute for the Zicsr read-modify-write forms, plus the write
// enable that drops set/clear writes whose rs1/zimm field is zero.
module ysyx_23060184_csr_alu
  import ysyx_23060184_csr_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] src,
  input  logic [4:0]            src_idx,
  output logic [DATA_WIDTH-1:0] new_val,
  output logic                  wen
);

  always_comb begin
    new_val = src;
    wen     = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin
        new_val = src;
        wen     = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_val = old_val | src;
        wen     = |src_idx;
      end
      F3_RC, F3_RCI: begin
        new_val = old_val & ~src;
        wen     = |src_idx;
      end
      default: begin
        new_val = src;
        wen     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_csr_access_unit.sv
// Initiator side of the CSR file port: one Zicsr/ecall/mret op per handshake,
// sequenced as read, then write/trap/return, then a held response.
//
// state | meaning
// IDLE  | ready for a request
// READ  | present latched CSR address, capture old value
// WRITE | one-cycle write of the RW/RS/RC result (may be suppressed)
// TRAP  | ecall strobe, capture mtvec as redirect target
// RET   | mret strobe, capture mepc as redirect target
// RESP  | hold response until out_ready
module ysyx_23060184_csr_access_unit
  import ysyx_23060184_csr_access_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    CSR_ADDR_LENGTH = 10,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE     = DATA_WIDTH'(CAUSE_ECALL_M)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_ecall,
  input  logic                       in_mret,
  input  logic [CSR_ADDR_LENGTH-1:0] in_csr,
  input  logic [DATA_WIDTH-1:0]      in_src,
  input  logic [4:0]                 in_src_idx,
  input  logic [4:0]                 in_rd,
  input  logic [DATA_WIDTH-1:0]      in_pc,
  output logic [CSR_ADDR_LENGTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0]      csr_rdata,
  output logic [CSR_ADDR_LENGTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0]      csr_wdata,
  output logic                       csr_wen,
  output logic                       csr_ecall,
  output logic                       csr_mret,
  output logic [DATA_WIDTH-1:0]      csr_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_rd,
  output logic                       out_rd_wen,
  output logic [DATA_WIDTH-1:0]      out_rd_data,
  output logic                       out_redirect,
  output logic [DATA_WIDTH-1:0]      out_redirect_pc,
  output logic                       out_illegal
);

  state_e                     state_q, state_d;
  logic [2:0]                 f3_q, f3_d;
  logic                       ecall_q, ecall_d;
  logic                       illegal_q, illegal_d;
  logic [CSR_ADDR_LENGTH-1:0] csr_q, csr_d;
  logic [DATA_WIDTH-1:0]      src_q, src_d;
  logic [4:0]                 idx_q, idx_d;
  logic [4:0]                 rd_q, rd_d;
  logic [DATA_WIDTH-1:0]      pc_q, pc_d;
  logic [DATA_WIDTH-1:0]      old_q, old_d;
  logic [DATA_WIDTH-1:0]      redir_q, redir_d;

  logic [DATA_WIDTH-1:0]      alu_new;
  logic                       alu_wen;
  logic                       req_illegal;
  logic                       is_zicsr_q;

  ysyx_23060184_csr_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .funct3 (f3_q),
    .old_val(old_q),
    .src    (src_q),
    .src_idx(idx_q),
    .new_val(alu_new),
    .wen    (alu_wen)
  );

  // A system op must be exactly one of ecall/mret; anything else is undefined.
  assign req_illegal = !f3_is_zicsr(in_funct3) &&
                       !((in_funct3 == F3_SYS) && (in_ecall ^ in_mret));
  assign is_zicsr_q  = f3_is_zicsr(f3_q) && !illegal_q;

  always_comb begin
    state_d         = state_q;
    f3_d            = f3_q;
    ecall_d         = ecall_q;
    illegal_d       = illegal_q;
    csr_d           = csr_q;
    src_d           = src_q;
    idx_d           = idx_q;
    rd_d            = rd_q;
    pc_d            = pc_q;
    old_d           = old_q;
    redir_d         = redir_q;
    in_ready        = 1'b0;
    csr_raddr       = '0;
    csr_waddr       = '0;
    csr_wdata       = '0;
    csr_wen         = 1'b0;
    csr_ecall       = 1'b0;
    csr_mret        = 1'b0;
    csr_pc          = '0;
    out_valid       = 1'b0;
    out_rd          = '0;
    out_rd_wen      = 1'b0;
    out_rd_data     = '0;
    out_redirect    = 1'b0;
    out_redirect_pc = '0;
    out_illegal     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          f3_d      = in_funct3;
          ecall_d   = in_ecall;
          illegal_d = req_illegal;
          csr_d     = in_csr;
          src_d     = in_src;
          idx_d     = in_src_idx;
          rd_d      = in_rd;
          pc_d      = in_pc;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        csr_raddr = csr_q;
        old_d     = csr_rdata;
        if (illegal_q)            state_d = ST_RESP;
        else if (f3_q != F3_SYS)  state_d = ST_WRITE;
        else if (ecall_q)         state_d = ST_TRAP;
        else                      state_d = ST_RET;
      end
      ST_WRITE: begin
        csr_wen   = alu_wen;
        csr_waddr = csr_q;
        csr_wdata = alu_new;
        state_d   = ST_RESP;
      end
      ST_TRAP: begin
        csr_ecall = 1'b1;
        csr_wdata = ECALL_CAUSE;
        csr_pc    = pc_q;
        csr_raddr = CSR_ADDR_LENGTH'(CSR_MTVEC);
        redir_d   = csr_rdata;
        state_d   = ST_RESP;
      end
      ST_RET: begin
        csr_mret  = 1'b1;
        csr_raddr = CSR_ADDR_LENGTH'(CSR_MEPC);
        redir_d   = csr_rdata;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        out_valid       = 1'b1;
        out_illegal     = illegal_q;
        out_rd          = is_zicsr_q ? rd_q : 5'd0;
        out_rd_wen      = is_zicsr_q && (rd_q != 5'd0);
        out_rd_data     = is_zicsr_q ? old_q : '0;
        out_redirect    = !illegal_q && (f3_q == F3_SYS);
        out_redirect_pc = out_redirect ? redir_q : '0;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      f3_q      <= '0;
      ecall_q   <= 1'b0;
      illegal_q <= 1'b0;
      csr_q     <= '0;
      src_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      old_q     <= '0;
      redir_q   <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      ecall_q   <= ecall_d;
      illegal_q <= illegal_d;
      csr_q     <= csr_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      old_q     <= old_d;
      redir_q   <= redir_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_csr_access_unit.sv
// Directed bench for the CSR access unit, paired with a small CSR file model
// (mstatus/mtvec/mepc/mcause) that counts strobes.
module tb_ysyx_23060184_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_ecall;
  logic        in_mret;
  logic [9:0]  in_csr;
  logic [31:0] in_src;
  logic [4:0]  in_src_idx;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic [9:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic [9:0]  csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        csr_ecall;
  logic        csr_mret;
  logic [31:0] csr_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;

  ysyx_23060184_csr_access_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_ecall(in_ecall), .in_mret(in_mret),
    .in_csr(in_csr), .in_src(in_src), .in_src_idx(in_src_idx),
    .in_rd(in_rd), .in_pc(in_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_ecall(csr_ecall), .csr_mret(csr_mret), .csr_pc(csr_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // CSR file model
  logic [31:0] mstatus_m, mtvec_m, mepc_m, mcause_m, last_wdata;
  int wen_cnt, ecall_cnt, mret_cnt, multi_cnt;

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_raddr)
      10'h300: csr_rdata = mstatus_m;
      10'h305: csr_rdata = mtvec_m;
      10'h341: csr_rdata = mepc_m;
      10'h342: csr_rdata = mcause_m;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (m_rst) begin
      mstatus_m  <= 32'h1800;
      mtvec_m    <= 32'h0;
      mepc_m     <= 32'h0;
      mcause_m   <= 32'h0;
      last_wdata <= 32'h0;
      wen_cnt    <= 0;
      ecall_cnt  <= 0;
      mret_cnt   <= 0;
      multi_cnt  <= 0;
    end else begin
      if (csr_wen) begin
        wen_cnt    <= wen_cnt + 1;
        last_wdata <= csr_wdata;
        case (csr_waddr)
          10'h300: mstatus_m <= csr_wdata;
          10'h305: mtvec_m   <= csr_wdata;
          10'h341: mepc_m    <= csr_wdata;
          10'h342: mcause_m  <= csr_wdata;
          default: ;
        endcase
      end
      if (csr_ecall) begin
        ecall_cnt <= ecall_cnt + 1;
        mcause_m  <= csr_wdata;
        mepc_m    <= csr_pc;
      end
      if (csr_mret) mret_cnt <= mret_cnt + 1;
      if (32'(csr_wen) + 32'(csr_ecall) + 32'(csr_mret) > 1) multi_cnt <= multi_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response snapshot from the last op
  logic [4:0]  r_rd;
  logic        r_rd_wen, r_redir, r_ill;
  logic [31:0] r_rd_data, r_redir_pc;
  int          r_lat, r_unstable, w0, e0, m0;

  task automatic run_op(input logic [2:0] f3, input logic ec, input logic mr,
                        input logic [9:0] csr, input logic [31:0] src,
                        input logic [4:0] idx, input logic [4:0] rd,
                        input logic [31:0] pc, input int hold);
    int guard;
    int e_hold, m_hold, w_hold;
    in_funct3 = f3; in_ecall = ec; in_mret = mr; in_csr = csr;
    in_src = src; in_src_idx = idx; in_rd = rd; in_pc = pc;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Garbage on the inputs must not reach the latched request.
    in_funct3 = 3'b100; in_ecall = 1'b1; in_mret = 1'b1; in_csr = 10'h3ff;
    in_src = 32'hffff_ffff; in_src_idx = 5'h1f; in_rd = 5'h1f; in_pc = 32'hdead_beef;
    r_lat = 1;
    while (!out_valid && r_lat < 10) begin
      @(posedge clk); #1; r_lat++;
    end
    r_rd = out_rd; r_rd_wen = out_rd_wen; r_rd_data = out_rd_data;
    r_redir = out_redirect; r_redir_pc = out_redirect_pc; r_ill = out_illegal;
    r_unstable = 0;
    w_hold = wen_cnt; e_hold = ecall_cnt; m_hold = mret_cnt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_rd != r_rd || out_rd_wen != r_rd_wen ||
          out_rd_data != r_rd_data || out_redirect != r_redir ||
          out_redirect_pc != r_redir_pc || out_illegal != r_ill ||
          csr_wen || csr_ecall || csr_mret)
        r_unstable++;
    end
    if (wen_cnt != w_hold || ecall_cnt != e_hold || mret_cnt != m_hold) r_unstable++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic mark();
    w0 = wen_cnt; e0 = ecall_cnt; m0 = mret_cnt;
  endtask

  initial begin
    rst = 1'b1; m_rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b0; in_ecall = 1'b0; in_mret = 1'b0; in_csr = 10'h0;
    in_src = 32'h0; in_src_idx = 5'h0; in_rd = 5'h0; in_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_strobes", {29'd0, csr_wen, csr_ecall, csr_mret}, 32'd0);
    chk("rst_raddr", 32'(csr_raddr), 32'd0);
    chk("rst_outs", {26'd0, out_rd_wen, out_redirect, out_illegal, 3'd0} | out_rd_data | out_redirect_pc, 32'd0);
    rst = 1'b0; m_rst = 1'b0;
    @(posedge clk); #1;

    // CSRRW mtvec
    mark();
    run_op(3'b001, 0, 0, 10'h305, 32'h8000_0100, 5'd2, 5'd5, 32'h0, 0);
    chk("rw_lat", 32'(r_lat), 32'd3);
    chk("rw_wen_cnt", 32'(wen_cnt - w0), 32'd1);
    chk("rw_mtvec", mtvec_m, 32'h8000_0100);
    chk("rw_rd_data", r_rd_data, 32'h0);
    chk("rw_rd_wen", 32'(r_rd_wen), 32'd1);
    chk("rw_rd", 32'(r_rd), 32'd5);
    chk("rw_redir", 32'(r_redir), 32'd0);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);

    // CSRRS with rs1=x0: read only
    mark();
    run_op(3'b010, 0, 0, 10'h300, 32'h0, 5'd0, 5'd6, 32'h0, 0);
    chk("rs0_wen_cnt", 32'(wen_cnt - w0), 32'd0);
    chk("rs0_rd_data", r_rd_data, 32'h1800);
    chk("rs0_lat", 32'(r_lat), 32'd3);

    // CSRRC mstatus, rd=x0
    mark();
    run_op(3'b011, 0, 0, 10'h300, 32'h0800, 5'd3, 5'd0, 32'h0, 0);
    chk("rc_wdata", last_wdata, 32'h1000);
    chk("rc_mstatus", mstatus_m, 32'h1000);
    chk("rc_rd_wen", 32'(r_rd_wen), 32'd0);

    // CSRRCI zimm=0: no write
    mark();
    run_op(3'b111, 0, 0, 10'h300, 32'h0, 5'd0, 5'd7, 32'h0, 0);
    chk("rci0_wen_cnt", 32'(wen_cnt - w0), 32'd0);
    chk("rci0_rd_data", r_rd_data, 32'h1000);
    chk("rci0_lat", 32'(r_lat), 32'd3);

    // CSRRSI zimm=5
    mark();
    run_op(3'b110, 0, 0, 10'h300, 32'h5, 5'd5, 5'd8, 32'h0, 0);
    chk("rsi_mstatus", mstatus_m, 32'h1005);
    chk("rsi_rd_data", r_rd_data, 32'h1000);

    // ecall
    mark();
    run_op(3'b000, 1, 0, 10'h0, 32'h0, 5'd0, 5'd0, 32'h8000_0040, 0);
    chk("ecall_cnt", 32'(ecall_cnt - e0), 32'd1);
    chk("ecall_wen_cnt", 32'(wen_cnt - w0), 32'd0);
    chk("ecall_mcause", mcause_m, 32'd11);
    chk("ecall_mepc", mepc_m, 32'h8000_0040);
    chk("ecall_redir", 32'(r_redir), 32'd1);
    chk("ecall_redir_pc", r_redir_pc, 32'h8000_0100);
    chk("ecall_rd_wen", 32'(r_rd_wen), 32'd0);
    chk("ecall_lat", 32'(r_lat), 32'd3);

    // mret
    mark();
    run_op(3'b000, 0, 1, 10'h0, 32'h0, 5'd0, 5'd0, 32'h0, 0);
    chk("mret_cnt", 32'(mret_cnt - m0), 32'd1);
    chk("mret_ecall_cnt", 32'(ecall_cnt - e0), 32'd0);
    chk("mret_redir", 32'(r_redir), 32'd1);
    chk("mret_redir_pc", r_redir_pc, 32'h8000_0040);
    chk("mret_rd_wen", 32'(r_rd_wen), 32'd0);

    // CSRRW mepc with out_ready held low 5 cycles
    mark();
    run_op(3'b001, 0, 0, 10'h341, 32'h1234, 5'd4, 5'd9, 32'h0, 5);
    chk("hold_unstable", 32'(r_unstable), 32'd0);
    chk("hold_rd_data", r_rd_data, 32'h8000_0040);
    chk("hold_wen_cnt", 32'(wen_cnt - w0), 32'd1);
    chk("hold_mepc", mepc_m, 32'h1234);

    // Illegal funct3=100
    mark();
    run_op(3'b100, 0, 0, 10'h300, 32'hffff, 5'd1, 5'd3, 32'h0, 0);
    chk("ill_lat", 32'(r_lat), 32'd2);
    chk("ill_flag", 32'(r_ill), 32'd1);
    chk("ill_rd_wen", 32'(r_rd_wen), 32'd0);
    chk("ill_redir", 32'(r_redir), 32'd0);
    chk("ill_strobes", 32'((wen_cnt - w0) + (ecall_cnt - e0) + (mret_cnt - m0)), 32'd0);

    // Illegal: ecall and mret both set
    mark();
    run_op(3'b000, 1, 1, 10'h0, 32'h0, 5'd0, 5'd0, 32'h8000_0080, 0);
    chk("ill2_flag", 32'(r_ill), 32'd1);
    chk("ill2_lat", 32'(r_lat), 32'd2);
    chk("ill2_strobes", 32'((wen_cnt - w0) + (ecall_cnt - e0) + (mret_cnt - m0)), 32'd0);

    // rst asserted while in READ
    mark();
    in_funct3 = 3'b001; in_ecall = 0; in_mret = 0; in_csr = 10'h305;
    in_src = 32'hdead_beef; in_src_idx = 5'd1; in_rd = 5'd1; in_pc = 32'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midrst_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_wen", 32'(csr_wen), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wen_cnt", 32'(wen_cnt - w0), 32'd0);
    chk("midrst_mtvec", mtvec_m, 32'h8000_0100);

    // Unit still works after the aborted op
    run_op(3'b010, 0, 0, 10'h305, 32'h0, 5'd0, 5'd1, 32'h0, 0);
    chk("post_rd_data", r_rd_data, 32'h8000_0100);
    chk("post_lat", 32'(r_lat), 32'd3);

    chk("multi_strobe", 32'(multi_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
